// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL manager endpoint: services Get/PutFullData/PutPartialData against a
// local word array and returns D-channel responses in order through a small queue.
module tl_ul_sram_responder #(
  parameter logic [31:0] BASE   = 32'h0000_0000,
  parameter int          DEPTH  = 64,
  parameter int          QDEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic [5:0]  a_source,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic [5:0]  d_source,
  output logic        d_denied,
  output logic        d_corrupt,
  output logic [31:0] d_data,
  output logic [7:0]  err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [31:0]   SPAN  = 32'(DEPTH * 4);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
  localparam logic [QW-1:0] QLAST = QW'(QDEPTH - 1);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [5:0]  source;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]   r_mem [DEPTH];
  rsp_t          r_q   [QDEPTH];
  logic [QW-1:0] r_wptr;
  logic [QW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_a_ready;
  logic [7:0]    r_err_count;

  logic [31:0]   w_offset;
  logic          w_in_range;
  logic [AW-1:0] w_index;
  logic          w_aligned;
  logic          w_is_get;
  logic          w_is_put;
  logic          w_legal;
  logic          w_a_fire;
  logic          w_d_fire;
  logic          w_d_valid;
  logic [CW-1:0] w_count_nxt;
  rsp_t          w_rsp;
  rsp_t          w_head;
  logic          w_unused;

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    return (p == QLAST) ? '0 : p + 1'b1;
  endfunction

  assign w_offset   = a_address - BASE;
  assign w_in_range = (w_offset < SPAN);
  assign w_index    = w_offset[AW+1:2];
  assign w_is_get   = (a_opcode == OP_GET);
  assign w_is_put   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
  assign w_unused   = ^{a_param, w_offset[1:0]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_aligned = 1'b0;
    case (a_size)
      4'd0:    w_aligned = 1'b1;
      4'd1:    w_aligned = ~a_address[0];
      4'd2:    w_aligned = (a_address[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  // Size > 2 already fails the alignment decode, so it needs no separate term.
  assign w_legal = w_in_range & w_aligned & (w_is_get | w_is_put);

  assign w_d_valid = (r_count != '0);
  assign w_a_fire  = a_valid & r_a_ready;
  assign w_d_fire  = w_d_valid & d_ready;

  always_comb begin
    w_rsp         = '0;
    w_rsp.opcode  = w_is_get ? OP_ACK_DATA : OP_ACK;
    w_rsp.size    = a_size;
    w_rsp.source  = a_source;
    w_rsp.denied  = ~w_legal;
    w_rsp.corrupt = w_is_get & ~w_legal;
    w_rsp.data    = (w_is_get & w_legal) ? r_mem[w_index] : 32'h0;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_a_fire && !w_d_fire)
      w_count_nxt = r_count + 1'b1;
    else if (!w_a_fire && w_d_fire)
      w_count_nxt = r_count - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_a_ready   <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      if (w_a_fire) r_wptr <= ptr_inc(r_wptr);
      if (w_d_fire) r_rptr <= ptr_inc(r_rptr);
      r_count   <= w_count_nxt;
      // Registered from the next count: a dequeue cannot reopen acceptance in the same cycle.
      r_a_ready <= (w_count_nxt != QFULL);
      if (w_d_fire && w_head.denied && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  // NOTE: array and queue storage carry no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (reset && w_a_fire && w_is_put && w_legal) begin
      for (int i = 0; i < 4; i++) begin
        if (a_mask[i]) r_mem[w_index][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset && w_a_fire) r_q[r_wptr] <= w_rsp;
  end

  // Payload is forced to zero whenever the queue is empty, including during reset.
  assign w_head    = w_d_valid ? r_q[r_rptr] : '0;

  assign a_ready   = r_a_ready;
  assign d_valid   = w_d_valid;
  assign d_opcode  = w_head.opcode;
  assign d_param   = 2'b00;
  assign d_size    = w_head.size;
  assign d_source  = w_head.source;
  assign d_denied  = w_head.denied;
  assign d_corrupt = w_head.corrupt;
  assign d_data    = w_head.data;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed bench for tl_ul_sram_responder: one task per scenario, inline comparisons
// against hand-computed responses.
module tb_tl_ul_sram_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clock;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [3:0]  a_size;
  logic [5:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [5:0]  d_source;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  tl_ul_sram_responder #(.BASE(BASE), .DEPTH(64), .QDEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .d_data(d_data), .err_count(err_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic [2:0] op, input logic [3:0] sz, input logic [5:0] src,
                       input logic [31:0] addr, input logic [3:0] m, input logic [31:0] dat);
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_mask    = m;
    a_data    = dat;
  endtask

  // Presents one request and returns #1 after the edge at which it fired.
  task automatic send_a(input logic [2:0] op, input logic [3:0] sz, input logic [5:0] src,
                        input logic [31:0] addr, input logic [3:0] m, input logic [31:0] dat);
    int n = 0;
    set_a(op, sz, src, addr, m, dat);
    a_valid = 1'b1;
    while (a_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL accept_timeout: src=%0d a_ready=%b after %0d cycles, required 1", src, a_ready, n);
    end else begin
      tick();
    end
    a_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; a_valid = 1'b0; d_ready = 1'b0; a_param = 3'd0;
    set_a(3'd0, 4'd0, 6'd0, 32'h0, 4'h0, 32'h0);
    repeat (3) tick();
    total++;
    if ({d_valid, a_ready, err_count, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data} !== 56'h0) begin
      bad++;
      $display("FAIL reset_state: v=%b rdy=%b err=%0d data=%h, required all zero", d_valid, a_ready, err_count, d_data);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({a_ready, d_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release: a_ready=%b d_valid=%b, required 1 0", a_ready, d_valid);
    end
  endtask

  task automatic test_put_get();
    d_ready = 1'b1;
    send_a(3'd0, 4'd2, 6'd5, BASE + 32'd8, 4'hF, 32'hDEADBEEF);
    total++;
    if ({d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt} !== {1'b1, 3'd0, 4'd2, 6'd5, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL put_ack: v=%b op=%0d src=%0d den=%b, required 1 0 5 0", d_valid, d_opcode, d_source, d_denied);
    end
    send_a(3'd4, 4'd2, 6'd6, BASE + 32'd8, 4'hF, 32'h0);
    total++;
    if ({d_valid, d_opcode, d_source, d_denied, d_corrupt, d_data} !== {1'b1, 3'd1, 6'd6, 1'b0, 1'b0, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL get_after_put: v=%b op=%0d src=%0d data=%h, required 1 1 6 deadbeef", d_valid, d_opcode, d_source, d_data);
    end
    tick();
    total++;
    if (d_valid !== 1'b0 || d_param !== 2'b00) begin
      bad++;
      $display("FAIL put_get_drain: d_valid=%b d_param=%0d, required 0 0", d_valid, d_param);
    end
  endtask

  task automatic test_partial();
    d_ready = 1'b1;
    send_a(3'd0, 4'd2, 6'd1, BASE + 32'd12, 4'hF, 32'hAABBCCDD);
    tick();
    send_a(3'd1, 4'd2, 6'd2, BASE + 32'd12, 4'b0101, 32'h11223344);
    total++;
    if ({d_valid, d_opcode, d_source, d_denied} !== {1'b1, 3'd0, 6'd2, 1'b0}) begin
      bad++;
      $display("FAIL partial_ack: op=%0d src=%0d den=%b, required 0 2 0", d_opcode, d_source, d_denied);
    end
    send_a(3'd4, 4'd2, 6'd3, BASE + 32'd12, 4'h0, 32'h0);
    total++;
    if ({d_valid, d_opcode, d_source, d_data} !== {1'b1, 3'd1, 6'd3, 32'hAA22CC44}) begin
      bad++;
      $display("FAIL partial_data: src=%0d data=%h, required 3 aa22cc44", d_source, d_data);
    end
    send_a(3'd4, 4'd0, 6'd4, BASE + 32'd13, 4'h2, 32'h0);
    total++;
    if ({d_valid, d_opcode, d_size, d_source, d_denied, d_data} !== {1'b1, 3'd1, 4'd0, 6'd4, 1'b0, 32'hAA22CC44}) begin
      bad++;
      $display("FAIL byte_get: size=%0d den=%b data=%h, required 0 0 aa22cc44", d_size, d_denied, d_data);
    end
    tick();
  endtask

  task automatic test_errors();
    d_ready = 1'b1;
    send_a(3'd4, 4'd2, 6'd7, BASE + 32'd256, 4'hF, 32'h0);
    total++;
    if ({d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data} !== {1'b1, 3'd1, 4'd2, 6'd7, 1'b1, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL get_out_of_range: op=%0d den=%b cor=%b data=%h, required 1 1 1 0", d_opcode, d_denied, d_corrupt, d_data);
    end
    send_a(3'd6, 4'd2, 6'd8, BASE, 4'hF, 32'h0);
    total++;
    if ({d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, err_count} !== {1'b1, 3'd0, 4'd2, 6'd8, 1'b1, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL bad_opcode: op=%0d src=%0d den=%b cor=%b err=%0d, required 0 8 1 0 1", d_opcode, d_source, d_denied, d_corrupt, err_count);
    end
    send_a(3'd4, 4'd1, 6'd9, BASE + 32'd9, 4'h3, 32'h0);
    total++;
    if ({d_opcode, d_size, d_source, d_denied, d_corrupt, err_count} !== {3'd1, 4'd1, 6'd9, 1'b1, 1'b1, 8'd2}) begin
      bad++;
      $display("FAIL misaligned_get: size=%0d den=%b err=%0d, required 1 1 2", d_size, d_denied, err_count);
    end
    send_a(3'd4, 4'd3, 6'd10, BASE, 4'hF, 32'h0);
    total++;
    if ({d_size, d_source, d_denied, d_corrupt} !== {4'd3, 6'd10, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL oversize_get: size=%0d den=%b cor=%b, required 3 1 1", d_size, d_denied, d_corrupt);
    end
    send_a(3'd4, 4'd2, 6'd11, BASE - 32'd4, 4'hF, 32'h0);
    total++;
    if ({d_source, d_denied, d_corrupt, d_data} !== {6'd11, 1'b1, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL below_base_get: den=%b data=%h, required 1 0", d_denied, d_data);
    end
    send_a(3'd0, 4'd2, 6'd12, BASE + 32'd10, 4'hF, 32'h0);
    total++;
    if ({d_opcode, d_source, d_denied, d_corrupt, err_count} !== {3'd0, 6'd12, 1'b1, 1'b0, 8'd5}) begin
      bad++;
      $display("FAIL misaligned_put: op=%0d den=%b err=%0d, required 0 1 5", d_opcode, d_denied, err_count);
    end
    send_a(3'd4, 4'd2, 6'd13, BASE + 32'd8, 4'hF, 32'h0);
    total++;
    if ({d_source, d_denied, d_data} !== {6'd13, 1'b0, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL denied_put_no_write: den=%b data=%h, required 0 deadbeef", d_denied, d_data);
    end
    tick();
    total++;
    if ({d_valid, err_count} !== {1'b0, 8'd6}) begin
      bad++;
      $display("FAIL err_count: d_valid=%b err=%0d, required 0 6", d_valid, err_count);
    end
  endtask

  task automatic test_backpressure();
    d_ready = 1'b1;
    send_a(3'd0, 4'd2, 6'd9, BASE + 32'd16, 4'hF, 32'h01234567);
    tick();
    d_ready = 1'b0;
    send_a(3'd4, 4'd2, 6'd10, BASE + 32'd8, 4'hF, 32'h0);
    send_a(3'd4, 4'd2, 6'd11, BASE + 32'd12, 4'hF, 32'h0);
    total++;
    if ({a_ready, d_valid, d_source, d_data} !== {1'b0, 1'b1, 6'd10, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL queue_full: a_ready=%b src=%0d data=%h, required 0 10 deadbeef", a_ready, d_source, d_data);
    end
    set_a(3'd4, 4'd2, 6'd12, BASE + 32'd16, 4'hF, 32'h0);
    a_valid = 1'b1;
    tick();
    total++;
    if ({a_ready, d_valid, d_opcode, d_source, d_data} !== {1'b0, 1'b1, 3'd1, 6'd10, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL stall_stable: a_ready=%b src=%0d data=%h, required 0 10 deadbeef", a_ready, d_source, d_data);
    end
    d_ready = 1'b1;
    tick();
    total++;
    if ({a_ready, d_valid, d_source, d_data} !== {1'b1, 1'b1, 6'd11, 32'hAA22CC44}) begin
      bad++;
      $display("FAIL drain_second: a_ready=%b src=%0d data=%h, required 1 11 aa22cc44", a_ready, d_source, d_data);
    end
    tick();
    a_valid = 1'b0;
    total++;
    if ({d_valid, d_source, d_data} !== {1'b1, 6'd12, 32'h01234567}) begin
      bad++;
      $display("FAIL third_accepted: v=%b src=%0d data=%h, required 1 12 01234567", d_valid, d_source, d_data);
    end
    tick();
    total++;
    if (d_valid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_drain: d_valid=%b, required 0", d_valid);
    end
  endtask

  task automatic test_reset_flush();
    d_ready = 1'b0;
    send_a(3'd4, 4'd2, 6'd20, BASE + 32'd8, 4'hF, 32'h0);
    send_a(3'd6, 4'd2, 6'd21, BASE, 4'hF, 32'h0);
    reset = 1'b0;
    tick();
    total++;
    if ({d_valid, a_ready, err_count, d_source, d_data} !== {1'b0, 1'b0, 8'd0, 6'd0, 32'h0}) begin
      bad++;
      $display("FAIL reset_flush: v=%b rdy=%b err=%0d data=%h, required 0 0 0 0", d_valid, a_ready, err_count, d_data);
    end
    reset = 1'b1;
    d_ready = 1'b1;
    tick();
    total++;
    if ({a_ready, d_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_flush_release: a_ready=%b d_valid=%b, required 1 0", a_ready, d_valid);
    end
    tick();
    total++;
    if (d_valid !== 1'b0) begin
      bad++;
      $display("FAIL stale_response: d_valid=%b src=%0d, required 0", d_valid, d_source);
    end
  endtask

  task automatic test_back_to_back();
    d_ready = 1'b1;
    a_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_a(3'd0, 4'd2, 6'(40 + k), BASE + 32'd32 + 32'(4 * k), 4'hF, 32'hC0DE_0000 + 32'(k));
      tick();
      total++;
      if ({d_valid, d_opcode, d_source, d_denied} !== {1'b1, 3'd0, 6'(40 + k), 1'b0}) begin
        bad++;
        $display("FAIL b2b_put[%0d]: v=%b op=%0d src=%0d, required 1 0 %0d", k, d_valid, d_opcode, d_source, 40 + k);
      end
    end
    for (int k = 0; k < 7; k++) begin
      set_a(3'd4, 4'd2, 6'(30 + k), BASE + 32'd32 + 32'(4 * k), 4'hF, 32'h0);
      tick();
      total++;
      if ({d_valid, d_opcode, d_source, d_data} !== {1'b1, 3'd1, 6'(30 + k), 32'hC0DE_0000 + 32'(k)}) begin
        bad++;
        $display("FAIL b2b_get[%0d]: v=%b src=%0d data=%h, required 1 %0d %h", k, d_valid, d_source, d_data, 30 + k, 32'hC0DE_0000 + 32'(k));
      end
    end
    a_valid = 1'b0;
    tick();
    total++;
    if (d_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_duplicate: d_valid=%b src=%0d, required 0", d_valid, d_source);
    end
  endtask

  task automatic test_err_saturate();
    d_ready = 1'b1;
    set_a(3'd6, 4'd2, 6'd50, BASE, 4'hF, 32'h0);
    a_valid = 1'b1;
    repeat (260) tick();
    a_valid = 1'b0;
    tick();
    total++;
    if ({d_valid, err_count} !== {1'b0, 8'd255}) begin
      bad++;
      $display("FAIL err_saturate: d_valid=%b err=%0d, required 0 255", d_valid, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_errors();
    test_backpressure();
    test_reset_flush();
    test_back_to_back();
    test_err_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
